// File: rtl/soml_frame_sequencer.sv
// soml_frame_sequencer: ping-pong frame buffer and launch control
// for soml_decoder_top, with result register, timeout and frame count.
module soml_frame_sequencer #(
  parameter int N           = 32,
  parameter int DEC_TIMEOUT = 256,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [N-1:0]     in_r,
  input  logic [N-1:0]     in_i,
  output logic             dec_start,
  output logic             dec_H_valid,
  output logic [N-1:0]     dec_H_r,
  output logic [N-1:0]     dec_H_i,
  output logic             dec_Y_valid,
  output logic [N-1:0]     dec_Y_r,
  output logic [N-1:0]     dec_Y_i,
  input  logic             dec_output_valid,
  input  logic [11:0]      dec_bits,
  input  logic [4:0]       dec_smin,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [11:0]      res_bits,
  output logic [4:0]       res_smin,
  output logic [CNT_W-1:0] frames_done,
  output logic             timeout_err,
  output logic             busy
);

  localparam int TW = (DEC_TIMEOUT > 2) ? $clog2(DEC_TIMEOUT) : 1;
  localparam logic [TW-1:0] TMO_LAST = TW'(DEC_TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_START,
    S_STREAM,
    S_WAIT
  } state_e;

  state_e state_q, state_d;

  logic [4:0]       wp_q;
  logic             wb_q;
  logic             rb_q;
  logic [1:0]       full_q, full_d;
  logic [3:0]       k_q;
  logic [3:0]       kn;
  logic [TW-1:0]    timer_q;
  logic [2*N-1:0]   mem_q [2][24];

  logic             hv_q, yv_q;
  logic [N-1:0]     hr_q, hi_q, yr_q, yi_q;
  logic             resv_q;
  logic [11:0]      resb_q;
  logic [4:0]       ress_q;
  logic [CNT_W-1:0] fd_q;
  logic             terr_q;

  logic             in_fire;
  logic             last_wr;
  logic             stream_end;
  logic             cap;
  logic             tmo;
  logic             load;
  logic [4:0]       h_addr;
  logic [4:0]       y_addr;
  logic [2*N-1:0]   h_word;
  logic [2*N-1:0]   y_word;

  assign in_ready   = rst && !full_q[wb_q];
  assign in_fire    = in_valid && in_ready;
  assign last_wr    = in_fire && (wp_q == 5'd23);
  assign stream_end = (state_q == S_STREAM) && (k_q == 4'd15);
  assign cap        = (state_q == S_WAIT) && dec_output_valid;
  assign tmo        = (state_q == S_WAIT) && !dec_output_valid
                      && (timer_q == TMO_LAST);

  // element index of the stream beat being loaded into the output regs
  assign kn   = (state_q == S_START) ? 4'd0 : k_q + 4'd1;
  assign load = (state_q == S_START)
                || ((state_q == S_STREAM) && (k_q != 4'd15));

  // column-major storage read out row-major: addr = (k%4)*4 + k/4
  assign h_addr = {1'b0, kn[1:0], kn[3:2]};
  assign y_addr = {2'b10, kn[2:0]};
  assign h_word = mem_q[rb_q][h_addr];
  assign y_word = mem_q[rb_q][y_addr];

  // bank fill / release; fill and release always target different banks
  always_comb begin
    full_d = full_q;
    if (stream_end) full_d[rb_q] = 1'b0;
    if (last_wr)    full_d[wb_q] = 1'b1;
  end

  // write pointer, write bank and bank-full flags
  always_ff @(posedge clk) begin
    if (!rst) begin
      wp_q   <= '0;
      wb_q   <= 1'b0;
      full_q <= '0;
    end else begin
      full_q <= full_d;
      if (in_fire) begin
        if (wp_q == 5'd23) begin
          wp_q <= '0;
          wb_q <= ~wb_q;
        end else begin
          wp_q <= wp_q + 5'd1;
        end
      end
    end
  end

  // sample storage; contents are don't-care until the bank is full
  always_ff @(posedge clk) begin
    if (in_fire) mem_q[wb_q][wp_q] <= {in_r, in_i};
  end

  // FSM state register
  always_ff @(posedge clk) begin
    if (!rst) state_q <= S_IDLE;
    else      state_q <= state_d;
  end

  // FSM next state
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:   if (full_q[rb_q] && !resv_q) state_d = S_START;
      S_START:  state_d = S_STREAM;
      S_STREAM: if (k_q == 4'd15) state_d = S_WAIT;
      S_WAIT:   if (cap || tmo) state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // FSM outputs
  always_comb begin
    dec_start = (state_q == S_START);
    busy      = (state_q != S_IDLE);
  end

  // stream index, read bank and result timer
  always_ff @(posedge clk) begin
    if (!rst) begin
      k_q     <= '0;
      rb_q    <= 1'b0;
      timer_q <= '0;
    end else begin
      if (state_q == S_START)       k_q <= '0;
      else if (state_q == S_STREAM) k_q <= k_q + 4'd1;
      if (stream_end) begin
        rb_q    <= ~rb_q;
        timer_q <= '0;
      end else if (state_q == S_WAIT) begin
        timer_q <= timer_q + 1'b1;
      end
    end
  end

  // registered H/Y drive; data holds when its valid drops
  always_ff @(posedge clk) begin
    if (!rst) begin
      hv_q <= 1'b0;
      yv_q <= 1'b0;
      hr_q <= '0;
      hi_q <= '0;
      yr_q <= '0;
      yi_q <= '0;
    end else if (load) begin
      hv_q <= 1'b1;
      hr_q <= h_word[2*N-1:N];
      hi_q <= h_word[N-1:0];
      yv_q <= !kn[3];
      if (!kn[3]) begin
        yr_q <= y_word[2*N-1:N];
        yi_q <= y_word[N-1:0];
      end
    end else begin
      hv_q <= 1'b0;
      yv_q <= 1'b0;
    end
  end

  // result capture, drain, frame count and sticky timeout
  always_ff @(posedge clk) begin
    if (!rst) begin
      resv_q <= 1'b0;
      resb_q <= '0;
      ress_q <= '0;
      fd_q   <= '0;
      terr_q <= 1'b0;
    end else begin
      if (cap) begin
        resv_q <= 1'b1;
        resb_q <= dec_bits;
        ress_q <= dec_smin;
        fd_q   <= fd_q + 1'b1;
      end else if (resv_q && res_ready) begin
        resv_q <= 1'b0;
      end
      if (tmo) terr_q <= 1'b1;
    end
  end

  assign dec_H_valid = hv_q;
  assign dec_H_r     = hr_q;
  assign dec_H_i     = hi_q;
  assign dec_Y_valid = yv_q;
  assign dec_Y_r     = yr_q;
  assign dec_Y_i     = yi_q;
  assign res_valid   = resv_q;
  assign res_bits    = resb_q;
  assign res_smin    = ress_q;
  assign frames_done = fd_q;
  assign timeout_err = terr_q;

endmodule

// File: tb/tb_soml_frame_sequencer.sv
// tb_soml_frame_sequencer: directed bench for soml_frame_sequencer
// (main instance default timeout, second instance DEC_TIMEOUT=16).
module tb_soml_frame_sequencer;

  localparam int N = 32;
  localparam logic [N-1:0] MASK = 32'hFFFF0000;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst = 1'b0;
  logic          rst2 = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_valid2 = 1'b0;
  logic [N-1:0]  in_r = '0;
  logic [N-1:0]  in_i = '0;
  logic          res_ready = 1'b1;
  logic          res_ready2 = 1'b0;

  logic          in_ready, dec_start, dec_H_valid, dec_Y_valid;
  logic [N-1:0]  dec_H_r, dec_H_i, dec_Y_r, dec_Y_i;
  logic          dov = 1'b0;
  logic          stray_dov = 1'b0;
  logic [11:0]   dbits = '0;
  logic [4:0]    dsmin = '0;
  logic          res_valid, timeout_err, busy;
  logic [11:0]   res_bits;
  logic [4:0]    res_smin;
  logic [15:0]   frames_done;

  logic          in_ready2, dec_start2, dec_H_valid2, dec_Y_valid2;
  logic [N-1:0]  dec_H_r2, dec_H_i2, dec_Y_r2, dec_Y_i2;
  logic          dov2 = 1'b0;
  logic [11:0]   dbits2 = '0;
  logic [4:0]    dsmin2 = '0;
  logic          res_valid2, timeout_err2, busy2;
  logic [11:0]   res_bits2;
  logic [4:0]    res_smin2;
  logic [15:0]   frames_done2;

  soml_frame_sequencer u_dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_r(in_r), .in_i(in_i),
    .dec_start(dec_start),
    .dec_H_valid(dec_H_valid), .dec_H_r(dec_H_r), .dec_H_i(dec_H_i),
    .dec_Y_valid(dec_Y_valid), .dec_Y_r(dec_Y_r), .dec_Y_i(dec_Y_i),
    .dec_output_valid(dov | stray_dov),
    .dec_bits(dbits), .dec_smin(dsmin),
    .res_valid(res_valid), .res_ready(res_ready),
    .res_bits(res_bits), .res_smin(res_smin),
    .frames_done(frames_done), .timeout_err(timeout_err), .busy(busy)
  );

  soml_frame_sequencer #(.DEC_TIMEOUT(16)) u_dut_t (
    .clk(clk), .rst(rst2),
    .in_valid(in_valid2), .in_ready(in_ready2),
    .in_r(in_r), .in_i(in_i),
    .dec_start(dec_start2),
    .dec_H_valid(dec_H_valid2), .dec_H_r(dec_H_r2), .dec_H_i(dec_H_i2),
    .dec_Y_valid(dec_Y_valid2), .dec_Y_r(dec_Y_r2), .dec_Y_i(dec_Y_i2),
    .dec_output_valid(dov2),
    .dec_bits(dbits2), .dec_smin(dsmin2),
    .res_valid(res_valid2), .res_ready(res_ready2),
    .res_bits(res_bits2), .res_smin(res_smin2),
    .frames_done(frames_done2), .timeout_err(timeout_err2), .busy(busy2)
  );

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int last_acc = 0;
  int n_acc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // decoder model: answers 40 cycles after each start pulse
  int mcnt = 0;
  int midx = 0;
  always @(negedge clk) begin
    dov = 1'b0;
    if (!rst) begin
      mcnt = 0;
      midx = 0;
    end else begin
      if (mcnt > 0) begin
        mcnt--;
        if (mcnt == 0) begin
          dov   = 1'b1;
          dbits = 12'hA5C + 12'(midx * 12'h111);
          dsmin = 5'(7 + midx);
          midx++;
        end
      end
      if (dec_start) mcnt = 40;
    end
  end

  // stream / result monitor for the main instance
  logic [N-1:0] hq[$];
  logic [N-1:0] hiq[$];
  logic [N-1:0] yq[$];
  logic [16:0]  rq[$];
  int n_start = 0;
  int start_cyc = -1;
  int h_first = -1;
  int y_last = -1;
  int res_cyc = -1;
  always @(negedge clk) begin
    if (!rst) begin
      hq.delete(); hiq.delete(); yq.delete(); rq.delete();
      n_start = 0; start_cyc = -1; h_first = -1;
      y_last = -1; res_cyc = -1;
    end else begin
      if (dec_start) begin
        n_start++;
        if (start_cyc < 0) start_cyc = cyc;
      end
      if (dec_H_valid) begin
        if (hq.size() == 0) h_first = cyc;
        hq.push_back(dec_H_r);
        hiq.push_back(dec_H_i);
      end
      if (dec_Y_valid) begin
        if (yq.size() < 8) y_last = cyc;
        yq.push_back(dec_Y_r);
      end
      if (res_valid && res_ready) begin
        rq.push_back({res_smin, res_bits});
        if (res_cyc < 0) res_cyc = cyc;
      end
    end
  end

  task automatic put(input bit which, input logic [N-1:0] v);
    bit ok;
    ok = 1'b0;
    in_r = v;
    in_i = v ^ MASK;
    if (which) in_valid2 = 1'b1;
    else       in_valid  = 1'b1;
    for (int n = 0; n < 3000 && !ok; n++) begin
      if (which ? in_ready2 : in_ready) begin
        ok = 1'b1;
        last_acc = cyc;
        n_acc++;
      end
      @(negedge clk);
    end
    if (!ok) chk("accept", 0, 1);
  endtask

  task automatic send_frame(input bit which, input logic [N-1:0] hb,
                            input logic [N-1:0] yb);
    for (int i = 0; i < 24; i++)
      put(which, (i < 16) ? hb + 32'(i) : yb + 32'(i - 16));
  endtask

  task automatic do_reset();
    rst = 1'b0;
    rst2 = 1'b0;
    in_valid = 1'b0;
    in_valid2 = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic wait_res(input int want, input int limit, input string tag);
    int n;
    n = 0;
    while (rq.size() < want && n < limit) begin
      @(negedge clk);
      n++;
    end
    chk(tag, 64'(rq.size() >= want), 1);
  endtask

  function automatic logic [N-1:0] h_exp(input logic [N-1:0] hb, input int k);
    return hb + 32'((k % 4) * 4 + k / 4);
  endfunction

  initial begin
    int base;
    int lacc2;
    int s2;
    int e2;
    bit found;

    // reset state
    rst = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst in_ready", in_ready, 0);
    rst = 1'b1;
    @(negedge clk);
    chk("rst flags", {dec_start, dec_H_valid, dec_Y_valid, res_valid,
                      timeout_err, busy}, 0);
    chk("rst data", {dec_H_r, dec_Y_r}, 0);
    chk("rst res", {res_smin, res_bits, frames_done}, 0);
    chk("rst in_ready rel", in_ready, 1);

    // single frame
    send_frame(0, 32'h100, 32'h200);
    in_valid = 1'b0;
    wait_res(1, 300, "single res wait");
    repeat (3) @(negedge clk);
    chk("single starts", n_start, 1);
    chk("single start lat", 64'(start_cyc - last_acc), 2);
    chk("single H lat", 64'(h_first - start_cyc), 1);
    chk("single H count", hq.size(), 16);
    for (int k = 0; k < 16; k++) begin
      chk($sformatf("single H%0d", k), hq[k], h_exp(32'h100, k));
      chk($sformatf("single Hi%0d", k), hiq[k], h_exp(32'h100, k) ^ MASK);
    end
    chk("single Y count", yq.size(), 8);
    for (int j = 0; j < 8; j++)
      chk($sformatf("single Y%0d", j), yq[j], 32'h200 + 32'(j));
    chk("single Y span", 64'(y_last - h_first), 7);
    chk("single res", rq[0], {5'd7, 12'hA5C});
    chk("single frames", frames_done, 1);
    chk("single H hold", dec_H_r, 32'h10F);
    chk("single Y hold", {dec_Y_r, dec_Y_i}, {32'h207, 32'h207 ^ MASK});
    chk("single idle", {busy, res_valid, timeout_err}, 0);

    // back-to-back, in_valid held high across frames
    do_reset();
    lacc2 = 0;
    for (int f = 0; f < 3; f++) begin
      base = 32'h1000 * (f + 1);
      send_frame(0, base, base + 32'h800);
      if (f == 1) lacc2 = last_acc;
    end
    in_valid = 1'b0;
    wait_res(3, 800, "b2b res wait");
    repeat (40) @(negedge clk);
    chk("b2b starts", n_start, 3);
    chk("b2b buffered", 64'(lacc2 < res_cyc), 1);
    for (int f = 0; f < 3; f++)
      chk($sformatf("b2b res%0d", f), rq[f],
          {5'(7 + f), 12'hA5C + 12'(f * 12'h111)});
    chk("b2b frames", frames_done, 3);
    chk("b2b H count", hq.size(), 48);
    for (int f = 0; f < 3; f++)
      for (int k = 0; k < 16; k++)
        chk($sformatf("b2b f%0d H%0d", f, k), hq[16 * f + k],
            h_exp(32'h1000 * (f + 1), k));

    // result backpressure
    do_reset();
    res_ready = 1'b0;
    send_frame(0, 32'h100, 32'h200);
    in_valid = 1'b0;
    found = 1'b0;
    for (int n = 0; n < 300 && !found; n++) begin
      @(negedge clk);
      found = res_valid;
    end
    chk("bp res1", found, 1);
    base = n_acc;
    send_frame(0, 32'h2000, 32'h2800);
    send_frame(0, 32'h3000, 32'h3800);
    chk("bp accepted", 64'(n_acc - base), 48);
    chk("bp in_ready", in_ready, 0);
    repeat (60) @(negedge clk);
    chk("bp in_ready held", in_ready, 0);
    chk("bp no start", n_start, 1);
    chk("bp frames", frames_done, 1);
    chk("bp res held", {res_valid, res_bits}, {1'b1, 12'hA5C});
    in_valid = 1'b0;
    @(posedge clk);
    #1 res_ready = 1'b1;
    wait_res(3, 800, "bp res wait");
    repeat (3) @(negedge clk);
    for (int f = 0; f < 3; f++)
      chk($sformatf("bp res%0d", f), rq[f],
          {5'(7 + f), 12'hA5C + 12'(f * 12'h111)});
    chk("bp frames end", frames_done, 3);
    chk("bp starts", n_start, 3);
    chk("bp f2 H0", hq[16], 32'h2000);
    chk("bp f3 H15", hq[47], 32'h300F);

    // timeout on the DEC_TIMEOUT=16 instance
    rst = 1'b0;
    rst2 = 1'b1;
    @(negedge clk);
    send_frame(1, 32'h300, 32'h400);
    in_valid2 = 1'b0;
    found = 1'b0;
    s2 = 0;
    for (int n = 0; n < 50 && !found; n++) begin
      if (dec_start2) begin found = 1'b1; s2 = cyc; end
      else @(negedge clk);
    end
    chk("tmo start", found, 1);
    found = 1'b0;
    e2 = 0;
    for (int n = 0; n < 100 && !found; n++) begin
      @(negedge clk);
      if (timeout_err2) begin found = 1'b1; e2 = cyc; end
    end
    chk("tmo seen", found, 1);
    chk("tmo timing", 64'(e2 - (s2 + 17)), 16);
    chk("tmo frames", frames_done2, 0);
    chk("tmo idle", {res_valid2, busy2}, 0);
    send_frame(1, 32'h500, 32'h580);
    in_valid2 = 1'b0;
    found = 1'b0;
    for (int n = 0; n < 50 && !found; n++) begin
      if (dec_start2) found = 1'b1;
      else @(negedge clk);
    end
    chk("tmo start2", found, 1);
    @(negedge clk);
    chk("tmo f2 H0", {dec_H_valid2, dec_H_r2}, {1'b1, 32'h500});
    chk("tmo f2 Y0", {dec_Y_valid2, dec_Y_r2}, {1'b1, 32'h580});
    repeat (20) @(negedge clk);
    dov2 = 1'b1;
    dbits2 = 12'h3C3;
    dsmin2 = 5'd19;
    @(negedge clk);
    dov2 = 1'b0;
    @(negedge clk);
    chk("tmo f2 res", {res_valid2, res_smin2, res_bits2},
        {1'b1, 5'd19, 12'h3C3});
    chk("tmo f2 frames", frames_done2, 1);
    chk("tmo sticky", timeout_err2, 1);

    // stray output_valid while idle
    do_reset();
    repeat (2) @(negedge clk);
    stray_dov = 1'b1;
    @(negedge clk);
    stray_dov = 1'b0;
    @(negedge clk);
    chk("stray res_valid", res_valid, 0);
    chk("stray frames", frames_done, 0);
    chk("stray busy", busy, 0);

    // reset in the middle of STREAM (k=5)
    send_frame(0, 32'h500, 32'h600);
    in_valid = 1'b0;
    found = 1'b0;
    for (int n = 0; n < 60 && !found; n++) begin
      @(negedge clk);
      if (dec_H_valid && dec_H_r == 32'h505) found = 1'b1;
    end
    chk("mid k5 seen", found, 1);
    rst = 1'b0;
    @(negedge clk);
    chk("mid flags", {dec_start, dec_H_valid, dec_Y_valid, res_valid,
                      timeout_err, busy}, 0);
    chk("mid H data", {dec_H_r, dec_H_i}, 0);
    chk("mid Y data", {dec_Y_r, dec_Y_i}, 0);
    chk("mid res", {res_smin, res_bits, frames_done}, 0);
    chk("mid in_ready rst", in_ready, 0);
    rst = 1'b1;
    @(negedge clk);
    chk("mid in_ready rel", in_ready, 1);
    send_frame(0, 32'h700, 32'h800);
    in_valid = 1'b0;
    wait_res(1, 300, "mid res wait");
    @(negedge clk);
    chk("mid res", rq[0], {5'd7, 12'hA5C});
    chk("mid starts", n_start, 1);
    chk("mid H1", hq[1], 32'h704);
    chk("mid H15", hq[15], 32'h70F);
    chk("mid Y7", yq[7], 32'h807);
    chk("mid frames", frames_done, 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

endmodule
